// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use bubble insertion and flush. Optional: ID_EX_PERF_EN (bubble counter).
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_stall,
  input  logic              i_id_valid,
  input  logic [XLEN-1:0]   i_id_pc,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic [REG_AW-1:0] i_id_rd_addr,
  input  logic [XLEN-1:0]   i_id_rs1_data,
  input  logic [XLEN-1:0]   i_id_rs2_data,
  input  logic [XLEN-1:0]   i_id_imm,
  input  logic [3:0]        i_id_alu_op,
  input  logic              i_id_opa_sel,
  input  logic              i_id_opb_sel,
  input  logic              i_id_rd_wren,
  input  logic              i_id_mem_rden,
  input  logic [REG_AW-1:0] i_mem_rd_addr,
  input  logic              i_mem_rd_wren,
  input  logic [XLEN-1:0]   i_mem_fwd_data,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic              i_wb_rd_wren,
  input  logic [XLEN-1:0]   i_wb_data,
  output logic              o_id_hold,
  output logic              o_ex_valid,
  output logic [XLEN-1:0]   o_ex_pc,
  output logic [REG_AW-1:0] o_ex_rd_addr,
  output logic              o_ex_rd_wren,
  output logic              o_ex_mem_rden,
  output logic [3:0]        o_alu_op,
  output logic [XLEN-1:0]   o_operand_a,
  output logic [XLEN-1:0]   o_operand_b,
`ifdef ID_EX_PERF_EN
  output logic [31:0]       o_bubble_cnt,
`endif
  output logic [XLEN-1:0]   o_store_data
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
    logic              rd_wren;
    logic              mem_rden;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [3:0]        alu_op;
    logic              opa_sel;
    logic              opb_sel;
  } ex_t;

  ex_t ex_q;
  ex_t ex_d;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic lu;

  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (i_mem_rd_wren && i_mem_rd_addr == ex_q.rs1_addr
        && ex_q.rs1_addr != '0)
      fwd_rs1 = i_mem_fwd_data;
    else if (i_wb_rd_wren && i_wb_rd_addr == ex_q.rs1_addr
             && ex_q.rs1_addr != '0)
      fwd_rs1 = i_wb_data;
  end

  always_comb begin
    fwd_rs2 = ex_q.rs2_data;
    if (i_mem_rd_wren && i_mem_rd_addr == ex_q.rs2_addr
        && ex_q.rs2_addr != '0)
      fwd_rs2 = i_mem_fwd_data;
    else if (i_wb_rd_wren && i_wb_rd_addr == ex_q.rs2_addr
             && ex_q.rs2_addr != '0)
      fwd_rs2 = i_wb_data;
  end

  assign o_ex_valid    = ex_q.valid;
  assign o_ex_pc       = ex_q.pc;
  assign o_ex_rd_addr  = ex_q.rd_addr;
  assign o_ex_rd_wren  = ex_q.rd_wren & ex_q.valid;
  assign o_ex_mem_rden = ex_q.mem_rden & ex_q.valid;
  assign o_alu_op      = ex_q.alu_op;

  assign lu = o_ex_mem_rden && ex_q.rd_addr != '0 && i_id_valid
           && (ex_q.rd_addr == i_id_rs1_addr
               || ex_q.rd_addr == i_id_rs2_addr);

  assign o_id_hold    = lu & ~i_flush;
  assign o_operand_a  = ex_q.opa_sel ? ex_q.pc : fwd_rs1;
  assign o_operand_b  = ex_q.opb_sel ? ex_q.imm : fwd_rs2;
  assign o_store_data = fwd_rs2;

  always_comb begin
    ex_d = ex_q;
    if (i_flush) begin
      ex_d = '0;
    end else if (i_stall) begin
      // keep re-capturing forwarded data so a retiring producer is not lost
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else if (lu) begin
      ex_d = '0;
    end else begin
      ex_d.valid    = i_id_valid;
      ex_d.pc       = i_id_pc;
      ex_d.rs1_addr = i_id_rs1_addr;
      ex_d.rs2_addr = i_id_rs2_addr;
      ex_d.rd_addr  = i_id_rd_addr;
      ex_d.rd_wren  = i_id_rd_wren;
      ex_d.mem_rden = i_id_mem_rden;
      ex_d.rs1_data = i_id_rs1_data;
      ex_d.rs2_data = i_id_rs2_data;
      ex_d.imm      = i_id_imm;
      ex_d.alu_op   = i_id_alu_op;
      ex_d.opa_sel  = i_id_opa_sel;
      ex_d.opb_sel  = i_id_opb_sel;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ex_q <= '0;
    else          ex_q <= ex_d;
  end

`ifdef ID_EX_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_bubble_cnt <= '0;
    else if (i_flush || (lu && !i_stall))
      o_bubble_cnt <= o_bubble_cnt + 32'd1;
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage in the branch-predicting RISC-V pipeline.
- Sits directly upstream of the ALU. Produces alu_op, operand_a and operand_b one cycle after decode.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, requests an IF/ID hold and inserts a bubble. Honours flush on branch mispredict.

Parameters:
- XLEN, 32, datapath width.
- REG_AW, 5, register address width.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset; asynchronous assert, active-low
- i_flush  in  1  mispredict flush from branch resolution
- i_stall  in  1  global stall (memory wait); freezes this stage
- i_id_valid  in  1  decode slot holds a real instruction
- i_id_pc  in  XLEN  decode PC
- i_id_rs1_addr / i_id_rs2_addr / i_id_rd_addr  in  REG_AW  register indices
- i_id_rs1_data / i_id_rs2_data  in  XLEN  register-file read data (register file is write-through)
- i_id_imm  in  XLEN  sign-extended immediate
- i_id_alu_op  in  4  ALU opcode (0000 = ADD)
- i_id_opa_sel  in  1  0 = rs1, 1 = PC
- i_id_opb_sel  in  1  0 = rs2, 1 = imm
- i_id_rd_wren  in  1  instruction writes rd
- i_id_mem_rden  in  1  instruction is a load
- i_mem_rd_addr  in  REG_AW  EX/MEM destination
- i_mem_rd_wren  in  1  EX/MEM destination write enable
- i_mem_fwd_data  in  XLEN  EX/MEM result
- i_wb_rd_addr  in  REG_AW  MEM/WB destination
- i_wb_rd_wren  in  1  MEM/WB destination write enable
- i_wb_data  in  XLEN  MEM/WB writeback value
- o_id_hold  out  1  load-use hold request to PC/IF-ID (combinational)
- o_ex_valid  out  1  EX slot valid
- o_ex_pc  out  XLEN  registered PC
- o_ex_rd_addr  out  REG_AW  registered rd
- o_ex_rd_wren  out  1  registered rd write enable, qualified by valid
- o_ex_mem_rden  out  1  registered load flag, qualified by valid
- o_alu_op  out  4  to ALU
- o_operand_a  out  XLEN  to ALU
- o_operand_b  out  XLEN  to ALU
- o_store_data  out  XLEN  forwarded rs2 for stores

Behaviour:
- Reset (i_rst_n low, asynchronous): all registers clear to 0. o_ex_valid=0, o_alu_op=0000, o_ex_rd_wren=0, o_ex_mem_rden=0, o_id_hold=0.
- Latency: decode fields captured on the rising edge. EX outputs valid in the following cycle.
- Load-use detection:
  - lu = o_ex_valid & o_ex_mem_rden & o_ex_rd_addr!=0 & i_id_valid & (o_ex_rd_addr==i_id_rs1_addr | o_ex_rd_addr==i_id_rs2_addr).
  - o_id_hold = lu & ~i_flush.
- Per-edge update priority:
  1. i_flush: all control fields cleared (valid, rd_wren, mem_rden, alu_op=0), data fields zeroed.
  2. i_stall: all fields held, except rs1/rs2 data registers, which reload with their forwarded values (addresses unchanged). A producer retiring during the stall is therefore not lost.
  3. lu: bubble inserted (same encoding as flush).
  4. Otherwise: load all decode fields.
- Forwarding, combinational on the registered rs addresses:
  - fwd_rsN = mem data if i_mem_rd_wren & i_mem_rd_addr==rsN & rsN!=0.
  - Else wb data if i_wb_rd_wren & i_wb_rd_addr==rsN & rsN!=0.
  - Else registered rsN data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operand selection:
  - o_operand_a = opa_sel ? pc : fwd_rs1.
  - o_operand_b = opb_sel ? imm : fwd_rs2.
  - o_store_data = fwd_rs2 regardless of opb_sel.
- Simultaneous events:
  - flush with lu: flush wins and o_id_hold=0.
  - stall with lu: stage holds and o_id_hold still asserts.
  - Invalid EX slot never triggers lu.
- Reset mid-stall: all state discarded; pipeline restarts with an empty EX slot.

Optional Feature:
- Macro ID_EX_PERF_EN.
- Defined: adds output o_bubble_cnt (32 bits), reset to 0. Increments on every edge where a bubble is inserted (flush or lu, stall not active). Wraps 0xFFFFFFFF to 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then ADD x3=x1+x2 (rs data 5, 7, no forwarding) -> next cycle o_alu_op=0000, o_operand_a=5, o_operand_b=7, o_ex_valid=1.
- EX/MEM writes x1=0x100 and MEM/WB writes x1=0x200 while EX uses rs1=x1 -> o_operand_a=0x100. With mem_rd_wren=0 -> 0x200. With rs1=x0 and both matching -> registered data.
- Load to x5 in EX, decode uses rs2=x5 -> o_id_hold=1 for one cycle, next EX slot has o_ex_valid=0, then the instruction issues with the forwarded load value.
- i_flush and lu asserted together -> o_id_hold=0, EX slot cleared, o_ex_rd_wren=0.
- i_stall for 3 cycles while MEM/WB forwards 0xDEAD to rs1 in the first stall cycle only -> o_operand_a stays 0xDEAD through the stall and after release.
- With ID_EX_PERF_EN: 2 flushes + 1 load-use bubble -> o_bubble_cnt=3. Preload 0xFFFFFFFF, one bubble -> 0.
